eq_coef_load_ctl: RTL and testbench

//  Sequences software writes of equaliser coefficients into the per-channel EQ coefficient RAM.

---
 rtl/eq_ctl_pkg.sv | 29 ++
 rtl/eq_ctl_edge_det.sv | 30 +++
 rtl/eq_coef_load_ctl.sv | 124 ++++++++++++
 tb/tb_eq_coef_load_ctl.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eq_ctl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : eq_ctl_pkg
//  Purpose  : Shared types and constants for the EQ coefficient load
//             controller: FSM state encoding, control-word bit positions
//             and default widths.
//  Revision : 1.0  initial release
// ============================================================================
package eq_ctl_pkg;

    // Sequencer states; FILL is unreachable when fill mode is not built in
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        FILL = 2'd2
    } eq_state_t;

    // Control-word layout
    localparam int CTL_W      = 32;
    localparam int STROBE_BIT = 31;
    localparam int FILL_BIT   = 30;
    localparam int ADDR_LSB   = 16;

    // Default geometry: 2048 channels, 16-bit coefficients
    localparam int EQ_ADDR_W  = 11;
    localparam int EQ_COEF_W  = 16;

endpackage : eq_ctl_pkg
`default_nettype wire

// File: rtl/eq_ctl_edge_det.sv
`default_nettype none
// ============================================================================
//  Module   : eq_ctl_edge_det
//  Purpose  : Registers the software strobe bit and flags any change of it
//             (rising or falling) as a new command.
//  Revision : 1.0  initial release
// ============================================================================
module eq_ctl_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic i_strobe,
    output logic o_toggle
);

    logic r_strobe_q;

    // Previous strobe value; cleared by reset so a strobe already high at
    // release counts as one command
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_strobe_q <= 1'b0;
        end else begin
            r_strobe_q <= i_strobe;
        end
    end

    assign o_toggle = i_strobe ^ r_strobe_q;

endmodule : eq_ctl_edge_det
`default_nettype wire

// File: rtl/eq_coef_load_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : eq_coef_load_ctl
//  Purpose  : Sequences software-issued writes of equaliser coefficients
//             into the per-channel coefficient RAM over a valid/ready port.
//             A command is any toggle of ctl_word[31]; it issues either a
//             single write or (with EQ_CTL_FILL_EN defined) a fill of every
//             channel with one coefficient.
//  Config   : EQ_CTL_FILL_EN - enables fill mode selected by ctl_word[30]
//  Revision : 1.0  initial release
// ============================================================================
module eq_coef_load_ctl
    import eq_ctl_pkg::*;
#(
    parameter int ADDR_W = EQ_ADDR_W,
    parameter int COEF_W = EQ_COEF_W
) (
    input  logic                user_clk,
    input  logic                user_rst_n,
    input  logic [CTL_W-1:0]    ctl_word,
    output logic                coef_valid,
    input  logic                coef_rdy,
    output logic [ADDR_W-1:0]   coef_addr,
    output logic [COEF_W-1:0]   coef_data,
    output logic                busy,
    output logic [15:0]         wr_count,
    output logic                cmd_dropped
);

    eq_state_t r_state;
    logic      w_toggle;
    logic      w_accept;
    logic      w_unused_ctl;

    // Not every control-word bit carries a field in every configuration
    assign w_unused_ctl = ^ctl_word;

    eq_ctl_edge_det u_edge_det (
        .clk      (user_clk),
        .rst_n    (user_rst_n),
        .i_strobe (ctl_word[STROBE_BIT]),
        .o_toggle (w_toggle)
    );

    // A beat completes in the cycle valid and ready are both high
    assign w_accept = coef_valid & coef_rdy;

    // Command sequencer with all outputs registered; ready only influences
    // the next-state decision, never valid in the same cycle
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            r_state     <= IDLE;
            coef_valid  <= 1'b0;
            coef_addr   <= '0;
            coef_data   <= '0;
            busy        <= 1'b0;
            wr_count    <= 16'd0;
            cmd_dropped <= 1'b0;
        end else begin
            // A command arriving while a previous one is still in flight
            // (including its final acceptance cycle) is discarded
            if (w_toggle && (r_state != IDLE)) begin
                cmd_dropped <= 1'b1;
            end

            if (w_accept) begin
                wr_count <= wr_count + 16'd1;
            end

            case (r_state)
                IDLE: begin
                    if (w_toggle) begin
                        coef_data  <= ctl_word[COEF_W-1:0];
                        coef_valid <= 1'b1;
                        busy       <= 1'b1;
`ifdef EQ_CTL_FILL_EN
                        if (ctl_word[FILL_BIT]) begin
                            r_state   <= FILL;
                            coef_addr <= '0;
                        end else begin
                            r_state   <= WR;
                            coef_addr <= ctl_word[ADDR_LSB +: ADDR_W];
                        end
`else
                        r_state   <= WR;
                        coef_addr <= ctl_word[ADDR_LSB +: ADDR_W];
`endif
                    end
                end

                WR: begin
                    if (w_accept) begin
                        r_state    <= IDLE;
                        coef_valid <= 1'b0;
                        busy       <= 1'b0;
                    end
                end

`ifdef EQ_CTL_FILL_EN
                FILL: begin
                    if (w_accept) begin
                        // Last channel written: stop, no wrap back to 0
                        if (&coef_addr) begin
                            r_state    <= IDLE;
                            coef_valid <= 1'b0;
                            busy       <= 1'b0;
                        end else begin
                            coef_addr <= coef_addr + 1'b1;
                        end
                    end
                end
`endif

                default: begin
                    r_state    <= IDLE;
                    coef_valid <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule : eq_coef_load_ctl
`default_nettype wire

// File: tb/tb_eq_coef_load_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_eq_coef_load_ctl
//  Purpose  : Directed self-checking bench for eq_coef_load_ctl. Scenarios
//             adapt to whether EQ_CTL_FILL_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
module tb_eq_coef_load_ctl;

    localparam int ADDR_W = 11;
    localparam int COEF_W = 16;
    localparam int NCHAN  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              user_rst_n = 1'b0;
    logic [31:0]       ctl_word = 32'd0;
    logic              coef_valid;
    logic              coef_rdy = 1'b0;
    logic [ADDR_W-1:0] coef_addr;
    logic [COEF_W-1:0] coef_data;
    logic              busy;
    logic [15:0]       wr_count;
    logic              cmd_dropped;

    int   checks   = 0;
    int   failures = 0;
    logic strobe_sw = 1'b0;
    int   exp_wr = 0;

    eq_coef_load_ctl #(.ADDR_W(ADDR_W), .COEF_W(COEF_W)) dut (
        .user_clk    (clk),
        .user_rst_n  (user_rst_n),
        .ctl_word    (ctl_word),
        .coef_valid  (coef_valid),
        .coef_rdy    (coef_rdy),
        .coef_addr   (coef_addr),
        .coef_data   (coef_data),
        .busy        (busy),
        .wr_count    (wr_count),
        .cmd_dropped (cmd_dropped)
    );

    always #5 clk = ~clk;

    // Build a control word whose strobe is the complement of the last one
    function automatic logic [31:0] next_word(input logic fill, input logic [10:0] addr,
                                              input logic [15:0] coef);
        strobe_sw = ~strobe_sw;
        return {strobe_sw, fill, 3'b000, addr, coef};
    endfunction

    // Drives a running fill with random ready; counts beats and protocol or
    // sequence errors. Optionally stops at a beat count or toggles the strobe.
    task automatic fill_run(input int stop_at, input int toggle_at, input logic [15:0] exp_data,
                            output int beats, output int seq_err);
        logic pv, pr, toggled;
        logic [ADDR_W-1:0] pa;
        beats = 0; seq_err = 0; pv = 1'b0; pr = 1'b0; pa = '0; toggled = 1'b0;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            if (beats == stop_at) break;
            if (pv && !pr && (!coef_valid || coef_addr !== pa)) seq_err++;
            if (!coef_valid) break;
            if (beats == toggle_at && !toggled) begin
                strobe_sw = ~strobe_sw;
                ctl_word[31] = strobe_sw;
                toggled = 1'b1;
            end
            coef_rdy = 1'($urandom_range(0, 1));
            if (coef_rdy) begin
                if (coef_addr !== beats[ADDR_W-1:0] || coef_data !== exp_data) seq_err++;
                beats++;
            end
            pv = coef_valid; pr = coef_rdy; pa = coef_addr;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        user_rst_n = 1'b0; ctl_word = 32'd0; coef_rdy = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if ({coef_valid, busy, cmd_dropped, coef_addr, coef_data, wr_count} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got v=%0b b=%0b d=%0b a=%h c=%h n=%0d exp all 0",
                     coef_valid, busy, cmd_dropped, coef_addr, coef_data, wr_count);
        end
        user_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (coef_valid !== 1'b0) begin
                failures++; $display("FAIL reset_release_valid got=%0b exp=0", coef_valid);
            end
        end
    endtask

    task automatic test_single();
        coef_rdy = 1'b1;
        ctl_word = next_word(1'b0, 11'h005, 16'h1234);
        @(negedge clk);
        checks++;
        if ({coef_valid, busy, coef_addr, coef_data} !== {1'b1, 1'b1, 11'h005, 16'h1234}) begin
            failures++;
            $display("FAIL single_beat got v=%0b b=%0b a=%h d=%h exp v=1 b=1 a=005 d=1234",
                     coef_valid, busy, coef_addr, coef_data);
        end
        exp_wr++;
        @(negedge clk);
        checks++;
        if ({coef_valid, busy, wr_count} !== {1'b0, 1'b0, 16'(exp_wr)}) begin
            failures++;
            $display("FAIL single_done got v=%0b b=%0b n=%0d exp v=0 b=0 n=%0d",
                     coef_valid, busy, wr_count, exp_wr);
        end
    endtask

    task automatic test_stall();
        coef_rdy = 1'b0;
        ctl_word = next_word(1'b0, 11'h005, 16'h1234);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if ({coef_valid, coef_addr, coef_data, wr_count} !==
                {1'b1, 11'h005, 16'h1234, 16'(exp_wr)}) begin
                failures++;
                $display("FAIL stall_hold cyc=%0d got v=%0b a=%h d=%h n=%0d exp v=1 a=005 d=1234 n=%0d",
                         i, coef_valid, coef_addr, coef_data, wr_count, exp_wr);
            end
        end
        coef_rdy = 1'b1;
        exp_wr++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({coef_valid, busy, wr_count} !== {1'b0, 1'b0, 16'(exp_wr)}) begin
                failures++;
                $display("FAIL stall_one_beat cyc=%0d got v=%0b b=%0b n=%0d exp v=0 b=0 n=%0d",
                         i, coef_valid, busy, wr_count, exp_wr);
            end
        end
    endtask

    task automatic test_fill();
        int beats, errs;
        ctl_word = next_word(1'b1, 11'h000, 16'h00AB);
        @(negedge clk);
`ifdef EQ_CTL_FILL_EN
        fill_run(-1, -1, 16'h00AB, beats, errs);
        exp_wr += NCHAN;
        checks++;
        if (beats !== NCHAN || errs !== 0) begin
            failures++; $display("FAIL fill_sequence got beats=%0d errs=%0d exp beats=%0d errs=0",
                                 beats, errs, NCHAN);
        end
`else
        coef_rdy = 1'b1;
        checks++;
        if ({coef_valid, coef_addr, coef_data} !== {1'b1, 11'h000, 16'h00AB}) begin
            failures++; $display("FAIL nofill_single got v=%0b a=%h d=%h exp v=1 a=000 d=00ab",
                                 coef_valid, coef_addr, coef_data);
        end
        exp_wr++;
        @(negedge clk);
`endif
        checks++;
        if ({coef_valid, busy, wr_count} !== {1'b0, 1'b0, 16'(exp_wr)}) begin
            failures++; $display("FAIL fill_done got v=%0b b=%0b n=%0d exp v=0 b=0 n=%0d",
                                 coef_valid, busy, wr_count, exp_wr);
        end
    endtask

    task automatic test_drop_during_fill();
        int beats, errs;
        checks++;
        if (cmd_dropped !== 1'b0) begin
            failures++; $display("FAIL drop_initial got=%0b exp=0", cmd_dropped);
        end
        ctl_word = next_word(1'b1, 11'h000, 16'h00AB);
`ifdef EQ_CTL_FILL_EN
        @(negedge clk);
        fill_run(-1, 10, 16'h00AB, beats, errs);
        exp_wr += NCHAN;
        checks++;
        if (beats !== NCHAN || errs !== 0) begin
            failures++; $display("FAIL drop_fill_unaffected got beats=%0d errs=%0d exp beats=%0d errs=0",
                                 beats, errs, NCHAN);
        end
`else
        coef_rdy = 1'b0;
        @(negedge clk);
        strobe_sw = ~strobe_sw;
        ctl_word[31] = strobe_sw;
        @(negedge clk);
        checks++;
        if ({coef_valid, coef_addr, cmd_dropped} !== {1'b1, 11'h000, 1'b1}) begin
            failures++; $display("FAIL drop_in_wr got v=%0b a=%h d=%0b exp v=1 a=000 d=1",
                                 coef_valid, coef_addr, cmd_dropped);
        end
        coef_rdy = 1'b1;
        exp_wr++;
        @(negedge clk);
`endif
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({coef_valid, busy, cmd_dropped, wr_count} !== {1'b0, 1'b0, 1'b1, 16'(exp_wr)}) begin
                failures++;
                $display("FAIL drop_discarded cyc=%0d got v=%0b b=%0b d=%0b n=%0d exp v=0 b=0 d=1 n=%0d",
                         i, coef_valid, busy, cmd_dropped, wr_count, exp_wr);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_burst();
        int beats, errs;
`ifdef EQ_CTL_FILL_EN
        ctl_word = next_word(1'b1, 11'h000, 16'h00CD);
        @(negedge clk);
        fill_run(100, -1, 16'h00CD, beats, errs);
        checks++;
        if (beats !== 100 || errs !== 0) begin
            failures++; $display("FAIL reset_mid_prefix got beats=%0d errs=%0d exp beats=100 errs=0",
                                 beats, errs);
        end
`else
        coef_rdy = 1'b0;
        ctl_word = next_word(1'b0, 11'h033, 16'h00CD);
        @(negedge clk);
`endif
        user_rst_n = 1'b0;
        strobe_sw = 1'b0;
        ctl_word = 32'd0;
        #1;
        checks++;
        if ({coef_valid, busy, wr_count, cmd_dropped} !== '0) begin
            failures++; $display("FAIL reset_mid_abort got v=%0b b=%0b n=%0d d=%0b exp all 0",
                                 coef_valid, busy, wr_count, cmd_dropped);
        end
        exp_wr = 0;
        repeat (2) @(negedge clk);
        user_rst_n = 1'b1;
        coef_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({coef_valid, busy} !== 2'b00) begin
                failures++; $display("FAIL reset_no_resume cyc=%0d got v=%0b b=%0b exp v=0 b=0",
                                     i, coef_valid, busy);
            end
        end
        ctl_word = next_word(1'b0, 11'h012, 16'h0055);
        @(negedge clk);
        checks++;
        if ({coef_valid, coef_addr, coef_data} !== {1'b1, 11'h012, 16'h0055}) begin
            failures++; $display("FAIL reset_fresh_cmd got v=%0b a=%h d=%h exp v=1 a=012 d=0055",
                                 coef_valid, coef_addr, coef_data);
        end
        exp_wr++;
        @(negedge clk);
        checks++;
        if ({coef_valid, wr_count} !== {1'b0, 16'(exp_wr)}) begin
            failures++; $display("FAIL reset_fresh_done got v=%0b n=%0d exp v=0 n=%0d",
                                 coef_valid, wr_count, exp_wr);
        end
    endtask

    task automatic test_back_to_back();
        checks++;
        if (cmd_dropped !== 1'b0) begin
            failures++; $display("FAIL b2b_initial_drop got=%0b exp=0", cmd_dropped);
        end
        coef_rdy = 1'b1;
        ctl_word = next_word(1'b0, 11'h7FF, 16'hBEEF);
        @(negedge clk);
        checks++;
        if ({coef_valid, coef_addr, coef_data} !== {1'b1, 11'h7FF, 16'hBEEF}) begin
            failures++; $display("FAIL b2b_first got v=%0b a=%h d=%h exp v=1 a=7ff d=beef",
                                 coef_valid, coef_addr, coef_data);
        end
        // New edge lands in the acceptance cycle and must be discarded
        ctl_word = next_word(1'b0, 11'h001, 16'h1111);
        exp_wr++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({coef_valid, busy, cmd_dropped, wr_count} !== {1'b0, 1'b0, 1'b1, 16'(exp_wr)}) begin
                failures++;
                $display("FAIL b2b_edge_at_accept cyc=%0d got v=%0b b=%0b d=%0b n=%0d exp v=0 b=0 d=1 n=%0d",
                         i, coef_valid, busy, cmd_dropped, wr_count, exp_wr);
            end
        end
    endtask

    task automatic test_release_cmd();
        user_rst_n = 1'b0;
        coef_rdy = 1'b1;
        strobe_sw = 1'b1;
        ctl_word = {1'b1, 1'b0, 3'b000, 11'h007, 16'h0042};
        repeat (3) @(negedge clk);
        checks++;
        if (coef_valid !== 1'b0) begin
            failures++; $display("FAIL release_in_reset got v=%0b exp=0", coef_valid);
        end
        user_rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({coef_valid, coef_addr, coef_data} !== {1'b1, 11'h007, 16'h0042}) begin
            failures++; $display("FAIL release_cmd got v=%0b a=%h d=%h exp v=1 a=007 d=0042",
                                 coef_valid, coef_addr, coef_data);
        end
        @(negedge clk);
        checks++;
        if ({coef_valid, busy, wr_count} !== {1'b0, 1'b0, 16'd1}) begin
            failures++; $display("FAIL release_once got v=%0b b=%0b n=%0d exp v=0 b=0 n=1",
                                 coef_valid, busy, wr_count);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_fill();
        test_drop_during_fill();
        test_reset_mid_burst();
        test_back_to_back();
        test_release_cmd();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop if the sequence ever stalls beyond any sane run length
    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout got=expired exp=finished");
        $fatal(1, "watchdog");
    end

endmodule : tb_eq_coef_load_ctl
`default_nettype wire
